ctrl_pipe_unit: RTL and testbench
=================================

CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

Interface
REQ-001 Parameter: STAGES, default 2, number of registered decode stages between instruction input and control output; legal range 1..4.
REQ-002 Parameter: ALU_W, default 5, width of the ALU control field.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  opcode/func3/func7 carry an instruction this cycle.
REQ-006 Port: in_ready  output  1  block accepts the instruction this cycle.
REQ-007 Port: opcode  input  7  instruction bits [6:0].
REQ-008 Port: func3  input  3  instruction bits [14:12].
REQ-009 Port: func7  input  7  instruction bits [31:25]; full field, not one bit.
REQ-010 Port: flush  input  1  kills every in-flight instruction.
REQ-011 Port: out_valid  output  1  ctrl_o holds a decoded bundle.
REQ-012 Port: out_ready  input  1  downstream consumes the bundle this cycle.
REQ-013 Port: ctrl_o  output  CTRL_W  packed bundle: reg_write, operand_a, operand_b, mem_en, s, l, sb, uj, jalr_i, u_aui, u_lui, mem_reg[1:0], imm_sel[2:0], alu_control[ALU_W-1:0], illegal.
REQ-014 Port: illegal_o  output  1  sticky flag: an illegal instruction reached the output.
REQ-015 Port: illegal_clr  input  1  clears illegal_o.

Function
REQ-016 Stage 0 decodes combinationally into a bundle; bundle plus valid bit then shift through STAGES registers; ctrl_o/out_valid come from the last register.
REQ-017 Latency: instruction accepted in cycle N appears with out_valid=1 in cycle N+STAGES when no stall occurs.
REQ-018 Transfer: accept when in_valid&&in_ready; consume when out_valid&&out_ready.
REQ-019 Per-stage ready: stage k advances when empty or stage k+1 advances; in_ready = stage 0 advances; full throughput of one instruction per cycle with out_ready held 1.
REQ-020 Stalled stage holds its bundle unchanged; ctrl_o stable while out_valid=1 and out_ready=0.
REQ-021 Decoded classes: R, I-ALU, load, store, branch, JAL, JALR, AUIPC, LUI, each with the team's existing control encoding.
REQ-022 Unknown opcode, or R-type func7 not 0000000/0100000 (nor 0000001 when M decode enabled): illegal=1, reg_write=0, mem_en=0, sb=0, uj=0, jalr_i=0, all else 0.
REQ-023 flush: all valid bits cleared next edge; instruction presented same cycle as flush is dropped; in_ready=1 during flush.
REQ-024 illegal_o sets in the cycle an illegal bundle is consumed; illegal_clr and set in same cycle: set wins.
REQ-025 Flushed illegal bundles never set illegal_o.

Reset
REQ-026 During rst_n=0: all stage valid bits 0, out_valid=0, illegal_o=0, ctrl_o all zeros, in_ready=1.
REQ-027 Reset asserted mid-stall discards all in-flight instructions; first accept possible in the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro RV32M_DECODE_EN: defined, R-type with func7=0000001 decodes the eight M operations to distinct alu_control codes (requires ALU_W>=5); undefined, that pattern is illegal.

Structure
REQ-029 Shared package holds opcode constants, alu_control codes including M codes, imm_sel codes, bundle field offsets and CTRL_W.
REQ-030 One sub-module, ctrl_decode_comb, holds the combinational decode; ctrl_pipe_unit holds stages, handshake, flush and sticky flag.

Verification
REQ-031 STAGES=2, out_ready=1, ADD (0110011/000/0000000) in cycle 0 -> out_valid=1 in cycle 2, reg_write=1, alu_control=ADD, illegal=0.
REQ-032 Stream SW, LW, BEQ back-to-back, out_ready=0 for 3 cycles after first output -> in_ready=0 once full, bundles emerge in order, none lost or duplicated.
REQ-033 Two instructions in flight, flush=1 with new in_valid=1 -> out_valid=0 for STAGES cycles, nothing emitted.
REQ-034 opcode 1111111 -> bundle illegal=1, reg_write=0, mem_en=0; illegal_o=1 after consumption; illegal_clr -> 0.
REQ-035 func7=0000001, func3=000: with RV32M_DECODE_EN -> alu_control=MUL, illegal=0; without -> illegal=1.
REQ-036 rst_n low for one cycle while stalled full -> out_valid=0 immediately, illegal_o=0, in_ready=1.

Source files
------------

// File: rtl/ctrl_pipe_unit_pkg.sv
// Shared decode constants for ctrl_pipe_unit: opcodes, ALU/imm/writeback codes, bundle layout.
// M-extension codes are consumed only when RV32M_DECODE_EN is defined.
package ctrl_pipe_unit_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] ALU_ADD     = 5'd0;
    localparam logic [4:0] ALU_SUB     = 5'd1;
    localparam logic [4:0] ALU_SLL     = 5'd2;
    localparam logic [4:0] ALU_SLT     = 5'd3;
    localparam logic [4:0] ALU_SLTU    = 5'd4;
    localparam logic [4:0] ALU_XOR     = 5'd5;
    localparam logic [4:0] ALU_SRL     = 5'd6;
    localparam logic [4:0] ALU_SRA     = 5'd7;
    localparam logic [4:0] ALU_OR      = 5'd8;
    localparam logic [4:0] ALU_AND     = 5'd9;
    localparam logic [4:0] ALU_PASSB   = 5'd10;
    // Branch compares occupy 16..23 and M operations 24..31, both indexed by func3
    localparam logic [4:0] ALU_BR_BASE = 5'd16;
    localparam logic [4:0] ALU_MUL     = 5'd24;
    localparam logic [4:0] ALU_MULH    = 5'd25;
    localparam logic [4:0] ALU_MULHSU  = 5'd26;
    localparam logic [4:0] ALU_MULHU   = 5'd27;
    localparam logic [4:0] ALU_DIV     = 5'd28;
    localparam logic [4:0] ALU_DIVU    = 5'd29;
    localparam logic [4:0] ALU_REM     = 5'd30;
    localparam logic [4:0] ALU_REMU    = 5'd31;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Bundle = {hi[HI_W-1:0], alu_control[ALU_W-1:0], illegal}; offsets below index hi
    localparam int HI_W          = 16;
    localparam int BIT_REG_WRITE = 15;
    localparam int BIT_OPERAND_A = 14;
    localparam int BIT_OPERAND_B = 13;
    localparam int BIT_MEM_EN    = 12;
    localparam int BIT_S         = 11;
    localparam int BIT_L         = 10;
    localparam int BIT_SB        = 9;
    localparam int BIT_UJ        = 8;
    localparam int BIT_JALR      = 7;
    localparam int BIT_U_AUI     = 6;
    localparam int BIT_U_LUI     = 5;
    localparam int BIT_MEM_REG   = 3;
    localparam int BIT_IMM_SEL   = 0;
    localparam int OFF_ILLEGAL   = 0;
    localparam int OFF_ALU       = 1;

    function automatic int ctrl_w(input int alu_w);
        return HI_W + alu_w + 1;
    endfunction

    localparam int CTRL_W = ctrl_w(5);

    function automatic logic [4:0] alu_of_func3(input logic [2:0] f3, input logic alt);
        logic [4:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Combinational instruction decode into the control bundle.
// RV32M_DECODE_EN enables decode of R-type func7=0000001 (M extension).
module ctrl_decode_comb
    import ctrl_pipe_unit_pkg::*;
#(
    parameter int ALU_W = 5
) (
    input  logic [6:0]               opcode,
    input  logic [2:0]               func3,
    input  logic [6:0]               func7,
    output logic [ctrl_w(ALU_W)-1:0] ctrl
);

    logic [HI_W-1:0] hi_s;
    logic [4:0]      alu5_s;
    logic            illegal_s;
    logic            r_func7_ok_s;

    // R-type func7 patterns recognised by this build
    always_comb begin
`ifdef RV32M_DECODE_EN
        r_func7_ok_s = (func7 == F7_BASE) || (func7 == F7_ALT) || (func7 == F7_MULDIV);
`else
        r_func7_ok_s = (func7 == F7_BASE) || (func7 == F7_ALT);
`endif
    end

    // Opcode class decode; illegal bundles keep every other field zero
    always_comb begin
        hi_s      = '0;
        alu5_s    = ALU_ADD;
        illegal_s = 1'b0;
        case (opcode)
            OP_R: begin
                if (!r_func7_ok_s) begin
                    illegal_s = 1'b1;
                end else if (func7 == F7_MULDIV) begin
                    hi_s[BIT_REG_WRITE] = 1'b1;
                    alu5_s              = ALU_MUL + {2'b00, func3};
                end else begin
                    hi_s[BIT_REG_WRITE] = 1'b1;
                    alu5_s              = alu_of_func3(func3, func7[5]);
                end
            end
            OP_I: begin
                hi_s[BIT_REG_WRITE]         = 1'b1;
                hi_s[BIT_OPERAND_B]         = 1'b1;
                hi_s[BIT_IMM_SEL +: 3]      = IMM_I;
                alu5_s = alu_of_func3(func3, (func3 == 3'b101) && func7[5]);
            end
            OP_LOAD: begin
                hi_s[BIT_REG_WRITE]         = 1'b1;
                hi_s[BIT_OPERAND_B]         = 1'b1;
                hi_s[BIT_MEM_EN]            = 1'b1;
                hi_s[BIT_L]                 = 1'b1;
                hi_s[BIT_MEM_REG +: 2]      = WB_MEM;
                hi_s[BIT_IMM_SEL +: 3]      = IMM_I;
            end
            OP_STORE: begin
                hi_s[BIT_OPERAND_B]         = 1'b1;
                hi_s[BIT_MEM_EN]            = 1'b1;
                hi_s[BIT_S]                 = 1'b1;
                hi_s[BIT_IMM_SEL +: 3]      = IMM_S;
            end
            OP_BRANCH: begin
                hi_s[BIT_SB]                = 1'b1;
                hi_s[BIT_IMM_SEL +: 3]      = IMM_B;
                alu5_s                      = ALU_BR_BASE + {2'b00, func3};
            end
            OP_JAL: begin
                hi_s[BIT_REG_WRITE]         = 1'b1;
                hi_s[BIT_OPERAND_A]         = 1'b1;
                hi_s[BIT_OPERAND_B]         = 1'b1;
                hi_s[BIT_UJ]                = 1'b1;
                hi_s[BIT_MEM_REG +: 2]      = WB_PC4;
                hi_s[BIT_IMM_SEL +: 3]      = IMM_J;
            end
            OP_JALR: begin
                hi_s[BIT_REG_WRITE]         = 1'b1;
                hi_s[BIT_OPERAND_B]         = 1'b1;
                hi_s[BIT_JALR]              = 1'b1;
                hi_s[BIT_MEM_REG +: 2]      = WB_PC4;
                hi_s[BIT_IMM_SEL +: 3]      = IMM_I;
            end
            OP_AUIPC: begin
                hi_s[BIT_REG_WRITE]         = 1'b1;
                hi_s[BIT_OPERAND_A]         = 1'b1;
                hi_s[BIT_OPERAND_B]         = 1'b1;
                hi_s[BIT_U_AUI]             = 1'b1;
                hi_s[BIT_IMM_SEL +: 3]      = IMM_U;
            end
            OP_LUI: begin
                hi_s[BIT_REG_WRITE]         = 1'b1;
                hi_s[BIT_OPERAND_B]         = 1'b1;
                hi_s[BIT_U_LUI]             = 1'b1;
                hi_s[BIT_IMM_SEL +: 3]      = IMM_U;
                alu5_s                      = ALU_PASSB;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    assign ctrl = {hi_s, ALU_W'(alu5_s), illegal_s};

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Decode pipeline: STAGES registered stages with per-stage ready, flush and sticky illegal flag.
// Build with RV32M_DECODE_EN to accept M-extension R-type instructions.
module ctrl_pipe_unit
    import ctrl_pipe_unit_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int ALU_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               func3,
    input  logic [6:0]               func7,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ctrl_w(ALU_W)-1:0] ctrl_o,
    output logic                     illegal_o,
    input  logic                     illegal_clr
);

    localparam int CW = ctrl_w(ALU_W);

    logic [CW-1:0]     dec_s;
    logic [CW-1:0]     data_r [STAGES];
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] adv_s;
    logic              set_s;
    logic              illegal_r;

    ctrl_decode_comb #(.ALU_W(ALU_W)) u_decode (
        .opcode (opcode),
        .func3  (func3),
        .func7  (func7),
        .ctrl   (dec_s)
    );

    // Ready chain: a stage moves when it is empty or its successor moves
    always_comb begin
        adv_s           = '0;
        adv_s[STAGES-1] = !valid_r[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv_s[k] = !valid_r[k] || adv_s[k+1];
        end
    end

    // Handshake-derived strobes; a flush suppresses the sticky-flag set
    always_comb begin
        in_ready = flush || adv_s[0];
        set_s    = valid_r[STAGES-1] && out_ready && data_r[STAGES-1][OFF_ILLEGAL] && !flush;
    end

    // Stage registers; flush clears valid bits but leaves data in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            if (adv_s[0]) begin
                valid_r[0] <= in_valid;
                if (in_valid) begin
                    data_r[0] <= dec_s;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv_s[k]) begin
                    valid_r[k] <= valid_r[k-1];
                    data_r[k]  <= data_r[k-1];
                end
            end
            if (flush) begin
                valid_r <= '0;
            end
        end
    end

    // Sticky illegal flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (set_s) begin
            illegal_r <= 1'b1;
        end else if (illegal_clr) begin
            illegal_r <= 1'b0;
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign ctrl_o    = data_r[STAGES-1];
    assign illegal_o = illegal_r;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit: queue-based reference model plus directed pins and random traffic.
module tb_ctrl_pipe_unit;

    localparam int STAGES = 2;
    localparam int ALU_W  = 5;
    localparam int CW     = 16 + ALU_W + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    opcode;
    logic [2:0]    func3;
    logic [6:0]    func7;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] ctrl_o;
    logic          illegal_o;
    logic          illegal_clr;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    ctrl_pipe_unit #(.STAGES(STAGES), .ALU_W(ALU_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ctrl_o      (ctrl_o),
        .illegal_o   (illegal_o),
        .illegal_clr (illegal_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode: each class's control bits written out as a hand-assembled constant
    function automatic logic [4:0] m_base_alu(input logic [2:0] f3);
        case (f3)
            3'd0: return 5'd0;
            3'd1: return 5'd2;
            3'd2: return 5'd3;
            3'd3: return 5'd4;
            3'd4: return 5'd5;
            3'd5: return 5'd6;
            3'd6: return 5'd8;
            default: return 5'd9;
        endcase
    endfunction

    function automatic logic [CW-1:0] m_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [15:0] hi;
        logic [4:0]  alu;
        logic        ill;
        hi = 16'h0000; alu = 5'd0; ill = 1'b0;
        case (op)
            7'b0110011: begin
                if (f7 == 7'h00 || f7 == 7'h20) begin
                    hi = 16'h8000;
                    if (f7 == 7'h20 && f3 == 3'd0)      alu = 5'd1;
                    else if (f7 == 7'h20 && f3 == 3'd5) alu = 5'd7;
                    else                                alu = m_base_alu(f3);
                end
`ifdef RV32M_DECODE_EN
                else if (f7 == 7'h01) begin
                    hi  = 16'h8000;
                    alu = 5'd24 + {2'b00, f3};
                end
`endif
                else ill = 1'b1;
            end
            7'b0010011: begin
                hi  = 16'hA001;
                alu = (f3 == 3'd5 && f7[5]) ? 5'd7 : m_base_alu(f3);
            end
            7'b0000011: hi = 16'hB409;
            7'b0100011: hi = 16'h3802;
            7'b1100011: begin hi = 16'h0203; alu = 5'd16 + {2'b00, f3}; end
            7'b1101111: hi = 16'hE115;
            7'b1100111: hi = 16'hA091;
            7'b0010111: hi = 16'hE044;
            7'b0110111: begin hi = 16'hA024; alu = 5'd10; end
            default:    ill = 1'b1;
        endcase
        return {hi, alu, ill};
    endfunction

    typedef struct {
        logic [CW-1:0] b;
        int            acc;
    } ent_t;

    ent_t q[$];
    int   cyc     = 0;
    logic ill_exp = 1'b0;

    // Compare process: every cycle, outputs against the queue model, then advance the model
    initial begin : compare
        logic ev, ir, consume;
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_illegal_o", 32'(illegal_o), 32'd0);
                check("rst_ctrl_o",    32'(ctrl_o),    32'd0);
                check("rst_in_ready",  32'(in_ready),  32'd1);
                q.delete();
                ill_exp = 1'b0;
            end else begin
                ev = (q.size() > 0) && (cyc >= q[0].acc + STAGES);
                ir = flush || (q.size() < STAGES) || out_ready;
                check("out_valid", 32'(out_valid), 32'(ev));
                check("in_ready",  32'(in_ready),  32'(ir));
                check("illegal_o", 32'(illegal_o), 32'(ill_exp));
                if (ev) check("ctrl_o", 32'(ctrl_o), 32'(q[0].b));
                consume = ev && out_ready;
                if (consume && !flush && q[0].b[0]) ill_exp = 1'b1;
                else if (illegal_clr)                ill_exp = 1'b0;
                if (flush) begin
                    q.delete();
                end else begin
                    if (consume) void'(q.pop_front());
                    if (in_valid && ir) begin
                        e.b   = m_decode(opcode, func3, func7);
                        e.acc = cyc;
                        q.push_back(e);
                    end
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        flush       = 1'b0;
        illegal_clr = 1'b0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        in_valid = 1'b1;
        opcode   = op;
        func3    = f3;
        func7    = f7;
    endtask

    // Drive one instruction with out_ready=1 and pin its bundle at the expected output cycle
    task automatic pin_one(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [CW-1:0] exp);
        drive(op, f3, f7);
        step();
        idle();
        repeat (STAGES - 1) step();
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_ctrl"},  32'(ctrl_o),    32'(exp));
    endtask

    function automatic logic [6:0] pick_op(input int i);
        case (i)
            0: return 7'b0110011;
            1: return 7'b0010011;
            2: return 7'b0000011;
            3: return 7'b0100011;
            4: return 7'b1100011;
            5: return 7'b1101111;
            6: return 7'b1100111;
            7: return 7'b0010111;
            8: return 7'b0110111;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [6:0] pick_f7(input int i);
        case (i)
            0: return 7'h00;
            1: return 7'h20;
            2: return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin : stim
        rst_n     = 1'b0;
        out_ready = 1'b1;
        opcode    = 7'd0;
        func3     = 3'd0;
        func7     = 7'd0;
        idle();
        repeat (2) step();
        rst_n = 1'b1;

        pin_one("add", 7'b0110011, 3'd0, 7'h00, 22'h200000);
        step();
        pin_one("lw", 7'b0000011, 3'd2, 7'h00, 22'h2D0240);
        step();
        pin_one("illegal", 7'b1111111, 3'd0, 7'h00, 22'h000001);
        check("illegal_o_before_consume", 32'(illegal_o), 32'd0);
        step();
        @(negedge clk);
        check("illegal_o_set", 32'(illegal_o), 32'd1);
        step();
        illegal_clr = 1'b1;
        step();
        illegal_clr = 1'b0;
        @(negedge clk);
        check("illegal_o_cleared", 32'(illegal_o), 32'd0);
        step();
`ifdef RV32M_DECODE_EN
        pin_one("mul", 7'b0110011, 3'd0, 7'h01, 22'h200030);
`else
        pin_one("mul", 7'b0110011, 3'd0, 7'h01, 22'h000001);
`endif
        step();
        illegal_clr = 1'b1;
        step();
        idle();

        // SW, LW, BEQ back-to-back into a stalled pipe
        out_ready = 1'b0;
        drive(7'b0100011, 3'd2, 7'h00); step();
        drive(7'b0000011, 3'd2, 7'h00); step();
        drive(7'b1100011, 3'd0, 7'h00);
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        idle();
        repeat (STAGES + 3) step();

        // Flush with two in flight and a new instruction presented
        out_ready = 1'b0;
        drive(7'b0110011, 3'd0, 7'h00); step();
        drive(7'b0000011, 3'd2, 7'h00); step();
        drive(7'b0100011, 3'd2, 7'h00);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        step();
        idle();
        out_ready = 1'b1;
        repeat (STAGES) begin
            @(negedge clk);
            check("post_flush_out_valid", 32'(out_valid), 32'd0);
            step();
        end

        // Reset pulse while the pipe is stalled full
        out_ready = 1'b0;
        drive(7'b1111111, 3'd0, 7'h00); step();
        drive(7'b0000011, 3'd2, 7'h00); step();
        drive(7'b0100011, 3'd2, 7'h00);
        step();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        check("rstpulse_out_valid", 32'(out_valid), 32'd0);
        check("rstpulse_in_ready",  32'(in_ready),  32'd1);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(7'b0110111, 3'd0, 7'h00);
        @(negedge clk);
        check("post_reset_accept", 32'(in_ready), 32'd1);
        step();
        idle();
        repeat (STAGES + 1) step();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            opcode      = pick_op($urandom_range(0, 10));
            func3       = 3'($urandom);
            func7       = pick_f7($urandom_range(0, 4));
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            illegal_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        out_ready = 1'b1;
        repeat (STAGES + 4) step();
        @(negedge clk);
        check("drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
